// File: rtl/neuron_accum_act_pkg.sv
// Shared types and conversion helpers for the neuron accumulate/activate back-end.
// Data is N-bit signed magnitude with F fraction bits; internal math is two's complement.
package nn_pkg;
    localparam int N         = 16;
    localparam int F         = 8;
    localparam int GUARD_DEF = 4;
    localparam int ACC_W     = N + GUARD_DEF;
    localparam int TC_W      = 32;

    localparam logic signed [TC_W-1:0] SAT_MAX = TC_W'(2**(N-1) - 1);

    typedef enum logic [1:0] {ACCUM, FINISH, OUT} state_t;

    // Negative zero has a zero magnitude, so it naturally maps to 0.
    function automatic logic signed [N:0] sm2tc(input logic [N-1:0] sm);
        logic signed [N:0] m;
        m = {2'b00, sm[N-2:0]};
        return sm[N-1] ? -m : m;
    endfunction

    function automatic logic [N-1:0] tc2sm_sat(input logic signed [TC_W-1:0] tc,
                                               output logic sat_flag);
        logic signed [TC_W-1:0] c;
        logic signed [TC_W-1:0] mag;
        sat_flag = (tc > SAT_MAX) || (tc < -SAT_MAX);
        if (tc > SAT_MAX)       c = SAT_MAX;
        else if (tc < -SAT_MAX) c = -SAT_MAX;
        else                    c = tc;
        mag = (c < 0) ? -c : c;
        return {c < 0, mag[N-2:0]};
    endfunction
endpackage

// File: rtl/neuron_accum_act_if.sv
// Upstream beat stream and downstream result handshake for one neuron back-end.
interface neuron_accum_act_if;
    import nn_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_sum;
    logic         in_last;
    logic [N-1:0] bias;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_sat;

    modport master (
        output in_valid, in_sum, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_sum, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neuron_accum_act_sm_to_tc.sv
// Combinational signed-magnitude to sign-extended two's-complement converter.
module sm_to_tc
    import nn_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [N-1:0]        sm,
    output logic signed [W-1:0] tc
);
    assign tc = W'(sm2tc(sm));
endmodule

// File: rtl/neuron_accum_act.sv
// Accumulates partial-sum beats of one neuron, adds bias, saturates, activates,
// and holds the registered result until the consumer takes it.
module neuron_accum_act
    import nn_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int GUARD     = 4,
    parameter int ACT_MODE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_accum_act_if.slave  bus,
    output logic               beat_ovf
);
    localparam int AW = N + GUARD;
    localparam int CW = $clog2(MAX_BEATS + 1);

    if (MAX_BEATS > (1 << GUARD)) begin : g_guard_chk
        $error("MAX_BEATS exceeds accumulator guard headroom");
    end
    if (AW + 1 > TC_W) begin : g_width_chk
        $error("accumulator too wide for saturation helper");
    end

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] in_tc;
    logic signed [AW:0]   bias_tc;
    logic signed [AW:0]   t;
    logic [CW-1:0]        cnt_q;
    logic                 take, at_max, sat;
    logic [N-1:0]         res;

    sm_to_tc #(.W(AW))     u_in_conv   (.sm(bus.in_sum), .tc(in_tc));
    sm_to_tc #(.W(AW + 1)) u_bias_conv (.sm(bus.bias),   .tc(bias_tc));

    // Gated by rst_n so the upstream sees not-ready for the whole reset window.
    assign bus.in_ready = rst_n && (state_q == ACCUM);
    assign take         = bus.in_valid && bus.in_ready;
    assign at_max       = (cnt_q == CW'(MAX_BEATS - 1));

    always_comb begin
        state_d = state_q;
        sat     = 1'b0;
        t       = (AW + 1)'(acc_q) + bias_tc;
        res     = tc2sm_sat(TC_W'(t), sat);
        if (ACT_MODE == 1 && t < 0) res = '0;
        case (state_q)
            ACCUM:   if (take && (bus.in_last || at_max)) state_d = FINISH;
            FINISH:  state_d = OUT;
            OUT:     if (bus.out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            acc_q         <= '0;
            cnt_q         <= '0;
            beat_ovf      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ACCUM: begin
                    if (take) begin
                        acc_q <= acc_q + in_tc;
                        cnt_q <= cnt_q + CW'(1);
                        if (at_max && !bus.in_last) beat_ovf <= 1'b1;
                    end
                end
                FINISH: begin
                    bus.out_data  <= res;
                    bus.out_sat   <= sat;
                    bus.out_valid <= 1'b1;
                    acc_q         <= '0;
                    cnt_q         <= '0;
                end
                OUT: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_accum_act.sv
// Bench: identity and ReLU instances driven in lockstep, checked against an integer model.
module tb_neuron_accum_act;
    logic clk = 1'b0;
    logic rst_n;
    logic ovf0, ovf1;

    logic        in_valid, in_last, out_ready;
    logic [15:0] in_sum, bias;

    logic [15:0] beats_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    neuron_accum_act_if i0 ();
    neuron_accum_act_if i1 ();

    assign i0.in_valid = in_valid;  assign i1.in_valid = in_valid;
    assign i0.in_sum   = in_sum;    assign i1.in_sum   = in_sum;
    assign i0.in_last  = in_last;   assign i1.in_last  = in_last;
    assign i0.bias     = bias;      assign i1.bias     = bias;
    assign i0.out_ready = out_ready; assign i1.out_ready = out_ready;

    neuron_accum_act #(.MAX_BEATS(16), .GUARD(4), .ACT_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(i0.slave), .beat_ovf(ovf0));
    neuron_accum_act #(.MAX_BEATS(16), .GUARD(4), .ACT_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.slave), .beat_ovf(ovf1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sm2i(input logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    // Reference: sum every beat as an integer, add bias, clip, activate, encode.
    function automatic logic [15:0] ref_out(input int mode, output logic sat);
        int t;
        t = sm2i(bias);
        foreach (beats_q[i]) t += sm2i(beats_q[i]);
        sat = 1'b0;
        if (t > 32767)  begin t = 32767;  sat = 1'b1; end
        if (t < -32767) begin t = -32767; sat = 1'b1; end
        if (mode == 1 && t < 0) t = 0;
        return (t < 0) ? {1'b1, 15'(-t)} : 16'(t);
    endfunction

    task automatic send(input logic [15:0] s, input logic l);
        int g = 0;
        in_valid = 1'b1; in_sum = s; in_last = l;
        @(negedge clk);
        while (!i0.in_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_neuron(input string tag, input int hold, input bit nolast);
        logic [15:0] e0, e1, d0;
        logic        s0, s1;
        foreach (beats_q[i]) send(beats_q[i], !nolast && (i == beats_q.size() - 1));
        chk({tag, "_lat_lo"}, i0.out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_lat_hi"}, {i0.out_valid, i1.out_valid}, 2'b11);
        e0 = ref_out(0, s0);
        e1 = ref_out(1, s1);
        chk({tag, "_data0"}, i0.out_data, e0);
        chk({tag, "_sat0"},  i0.out_sat,  s0);
        chk({tag, "_data1"}, i1.out_data, e1);
        chk({tag, "_sat1"},  i1.out_sat,  s1);
        d0 = i0.out_data;
        for (int c = 0; c < hold; c++) begin
            in_valid = c[0]; in_sum = 16'h1234; in_last = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_bp_vld"},  i0.out_valid, 1);
            chk({tag, "_bp_data"}, i0.out_data, d0);
            chk({tag, "_bp_rdy"},  i0.in_ready, 0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drain"}, {i0.out_valid, i1.out_valid}, 2'b00);
        chk({tag, "_rdy_next"}, i0.in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_sum = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", i0.in_ready, 0);
        chk("rst_out_valid", i0.out_valid, 0);
        chk("rst_out_data", i0.out_data, 0);
        chk("rst_out_sat", i0.out_sat, 0);
        chk("rst_ovf", {ovf0, ovf1}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", i0.in_ready, 1);

        bias = 16'h0080; beats_q = '{16'h0100};
        run_neuron("single", 0, 0);
        chk("single_val", i0.out_data, 16'h0180);

        bias = 16'h0000; beats_q = '{16'h0100, 16'h8300, 16'h0080};
        run_neuron("mix", 0, 0);
        chk("mix_id", i0.out_data, 16'h8180);
        chk("mix_relu", i1.out_data, 16'h0000);

        beats_q = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        run_neuron("satp", 0, 0);
        chk("satp_val", {i0.out_sat, i0.out_data}, {1'b1, 16'h7FFF});
        beats_q = '{16'hF000, 16'hF000, 16'hF000, 16'hF000};
        run_neuron("satn", 0, 0);
        chk("satn_val", {i0.out_sat, i0.out_data}, {1'b1, 16'hFFFF});

        bias = 16'h0040; beats_q = '{16'h0200, 16'h8100};
        run_neuron("bp", 5, 0);

        bias = 16'h8000; beats_q = '{16'h8000};
        run_neuron("negz", 0, 0);
        chk("negz_val", {i0.out_data, i1.out_data}, 32'h0);

        chk("ovf_pre", {ovf0, ovf1}, 0);
        bias = 16'h0000; beats_q = {};
        for (int i = 0; i < 16; i++) beats_q.push_back(16'h0010);
        run_neuron("maxb", 0, 1);
        chk("maxb_val", i0.out_data, 16'h0100);
        chk("ovf_set", {ovf0, ovf1}, 2'b11);

        for (int n = 0; n < 20; n++) begin
            int nb;
            nb = $urandom_range(1, 6);
            beats_q = {};
            for (int b = 0; b < nb; b++)
                beats_q.push_back($urandom_range(0, 1) ? 16'($urandom)
                                  : {1'($urandom), 15'($urandom_range(0, 16'h0800))});
            bias = 16'($urandom);
            run_neuron("rand", $urandom_range(0, 2), 0);
        end
        chk("ovf_sticky", {ovf0, ovf1}, 2'b11);

        bias = 16'h0000;
        send(16'h0300, 1'b0);
        send(16'h0300, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", i0.in_ready, 0);
        chk("mid_rst_ovf", {ovf0, ovf1}, 0);
        chk("mid_rst_vld", i0.out_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        beats_q = '{16'h0100};
        run_neuron("post_rst", 0, 0);
        chk("post_rst_val", i0.out_data, 16'h0100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
